// File: rtl/card_pkg.sv
// Card encoding and deal-FSM state set shared by the dealer, the 7-segment decoder and scoring logic.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_ERR      = 2'd2,
    S_WAIT_LOW = 2'd3
  } deal_state_t;

  // Rank sequence is 1..max_rank then back to ace; blank is never produced.
  function automatic card_t next_rank(input card_t rank, input card_t max_rank);
    return (rank >= max_rank) ? CARD_ACE : card_t'(rank + 4'd1);
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Four-phase deal handshake plus the last-dealt card value.
interface card_dealer_if;
  import card_pkg::*;

  logic  clear;
  logic  deal_req;
  logic  deal_to;
  logic  deal_ack;
  logic  deal_err;
  card_t card_value;

  modport master (
    output clear, deal_req, deal_to,
    input  deal_ack, deal_err, card_value
  );

  modport slave (
    input  clear, deal_req, deal_to,
    output deal_ack, deal_err, card_value
  );

endinterface

// File: rtl/card_dealer_rank_counter.sv
// Free-running rank counter 1..MAX_RANK; independent of clear and the deal FSM.
module rank_counter
  import card_pkg::*;
#(
  parameter int MAX_RANK = 13
) (
  input  logic  clk,
  input  logic  resetb,
  output card_t rank
);

  localparam card_t RANK_TOP = card_t'(MAX_RANK);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rank <= CARD_ACE;
    end else begin
      rank <= next_rank(rank, RANK_TOP);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deal FSM and the player/dealer hand registers; each accepted request captures the current rank.
//
// state      | meaning
// S_IDLE     | waiting for deal_req; deals or flags a full hand on the edge it is seen
// S_ACK      | deal done, deal_ack held until deal_req drops
// S_ERR      | target hand full, deal_err held until deal_req drops
// S_WAIT_LOW | after clear, block a still-held request from dealing into the new round
module card_dealer
  import card_pkg::*;
#(
  parameter  int HAND_SIZE = 3,
  parameter  int MAX_RANK  = 13,
  localparam int CW        = $clog2(HAND_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   resetb,
  card_dealer_if.slave           deal,
  output logic [4*HAND_SIZE-1:0] player_cards,
  output logic [4*HAND_SIZE-1:0] dealer_cards,
  output logic [CW-1:0]          player_count,
  output logic [CW-1:0]          dealer_count
);

  localparam logic [CW-1:0] COUNT_FULL = CW'(HAND_SIZE);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  card_t       rank;
  deal_state_t state;
  card_t       player_hand [HAND_SIZE];
  card_t       dealer_hand [HAND_SIZE];
  logic        ack;
  logic        err;
  card_t       last_card;
  logic        target_full;

  rank_counter #(
    .MAX_RANK (MAX_RANK)
  ) u_rank_counter (
    .clk    (clk),
    .resetb (resetb),
    .rank   (rank)
  );

  assign target_full = deal.deal_to ? (dealer_count == COUNT_FULL)
                                    : (player_count == COUNT_FULL);

  // Slots are only written at index count and cleared together, so slots above count stay blank.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state        <= S_IDLE;
      ack          <= 1'b0;
      err          <= 1'b0;
      last_card    <= CARD_BLANK;
      player_count <= '0;
      dealer_count <= '0;
      for (int i = 0; i < HAND_SIZE; i++) begin
        player_hand[i] <= CARD_BLANK;
        dealer_hand[i] <= CARD_BLANK;
      end
    end else if (deal.clear) begin
      state        <= S_WAIT_LOW;
      ack          <= 1'b0;
      err          <= 1'b0;
      last_card    <= CARD_BLANK;
      player_count <= '0;
      dealer_count <= '0;
      for (int i = 0; i < HAND_SIZE; i++) begin
        player_hand[i] <= CARD_BLANK;
        dealer_hand[i] <= CARD_BLANK;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (deal.deal_req) begin
            if (target_full) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              if (deal.deal_to) begin
                dealer_hand[dealer_count] <= rank;
                dealer_count              <= dealer_count + COUNT_ONE;
              end else begin
                player_hand[player_count] <= rank;
                player_count              <= player_count + COUNT_ONE;
              end
              last_card <= rank;
              ack       <= 1'b1;
              state     <= S_ACK;
            end
          end
        end
        S_ACK, S_ERR: begin
          if (!deal.deal_req) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_WAIT_LOW: begin
          if (!deal.deal_req) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign deal.deal_ack   = ack;
  assign deal.deal_err   = err;
  assign deal.card_value = last_card;

  always_comb begin
    player_cards = '0;
    dealer_cards = '0;
    for (int i = 0; i < HAND_SIZE; i++) begin
      player_cards[4*i +: 4] = player_hand[i];
      dealer_cards[4*i +: 4] = dealer_hand[i];
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, capture, rank wrap, full hand, held request, clear and reset.
module tb_card_dealer;
  import card_pkg::*;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [11:0] player_cards;
  logic [11:0] dealer_cards;
  logic [1:0]  player_count;
  logic [1:0]  dealer_count;
  int          n_checks = 0;
  int          n_fail = 0;
  int          mrank;

  card_dealer_if dif ();

  card_dealer #(
    .HAND_SIZE (3),
    .MAX_RANK  (13)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .deal         (dif),
    .player_cards (player_cards),
    .dealer_cards (dealer_cards),
    .player_count (player_count),
    .dealer_count (dealer_count)
  );

  always #5 clk = ~clk;

  // Reference rank, used only to line up a request with a wanted rank.
  always @(posedge clk or negedge resetb) begin
    if (!resetb) mrank <= 1;
    else         mrank <= (mrank == 13) ? 1 : mrank + 1;
  end

  task automatic wait_rank(input int r);
    int i = 0;
    while (mrank != r && i < 20) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (mrank != r) begin
      n_fail++;
      $display("FAIL wait_rank: rank %0d not reached (at %0d)", r, mrank);
    end
  endtask

  // Called at a negedge in S_IDLE; returns at a negedge with the FSM back in S_IDLE.
  task automatic deal(input logic to, input card_t exp_val, input string name);
    dif.deal_to  = to;
    dif.deal_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dif.deal_ack !== 1'b1 || dif.deal_err !== 1'b0 || dif.card_value !== exp_val) begin
      n_fail++;
      $display("FAIL %s: ack=%b err=%b card=%0d, want ack=1 err=0 card=%0d",
               name, dif.deal_ack, dif.deal_err, dif.card_value, exp_val);
    end
    dif.deal_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dif.deal_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: ack=%b want 0", name, dif.deal_ack);
    end
  endtask

  task automatic do_clear();
    dif.clear = 1'b1;
    @(negedge clk);
    dif.clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (player_cards !== 12'h0 || dealer_cards !== 12'h0 || player_count !== 2'd0 ||
        dealer_count !== 2'd0 || dif.card_value !== 4'd0 || dif.deal_ack !== 1'b0 ||
        dif.deal_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: p=%h d=%h pc=%0d dc=%0d card=%0d ack=%b err=%b, want all 0",
               player_cards, dealer_cards, player_count, dealer_count, dif.card_value,
               dif.deal_ack, dif.deal_err);
    end
  endtask

  task automatic test_reset();
    dif.clear = 1'b0; dif.deal_req = 1'b0; dif.deal_to = 1'b0;
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (player_cards !== 12'h0 || dealer_cards !== 12'h0 || player_count !== 2'd0 ||
        dealer_count !== 2'd0 || dif.card_value !== 4'd0 || dif.deal_ack !== 1'b0 ||
        dif.deal_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: p=%h d=%h pc=%0d dc=%0d card=%0d ack=%b err=%b, want all 0",
               player_cards, dealer_cards, player_count, dealer_count, dif.card_value,
               dif.deal_ack, dif.deal_err);
    end
    resetb = 1'b1;
    // Ranks after release are 1,2,3: deals on the 1st and 3rd edges capture 1 and 3.
    deal(1'b0, 4'd1, "reset_rank1");
    deal(1'b0, 4'd3, "reset_rank3");
    n_checks++;
    if (player_cards !== 12'h031 || player_count !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_seq: p=%h pc=%0d, want 031 2", player_cards, player_count);
    end
    #2 resetb = 1'b0;
    #1;
    n_checks++;
    if (player_cards !== 12'h0 || player_count !== 2'd0 || dif.card_value !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_midrun: p=%h pc=%0d card=%0d, want 0 0 0",
               player_cards, player_count, dif.card_value);
    end
    @(negedge clk);
    resetb = 1'b1;
  endtask

  task automatic test_capture();
    wait_rank(5);
    deal(1'b0, 4'd5, "capture");
    n_checks++;
    if (player_cards !== 12'h005 || player_count !== 2'd1 || dealer_count !== 2'd0) begin
      n_fail++;
      $display("FAIL capture_slot: p=%h pc=%0d dc=%0d, want 005 1 0",
               player_cards, player_count, dealer_count);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    wait_rank(12);
    deal(1'b0, 4'd12, "wrap_12");
    deal(1'b0, 4'd1,  "wrap_ace");
    deal(1'b0, 4'd3,  "wrap_3");
    n_checks++;
    if (player_cards !== 12'h31C || player_count !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_hand: p=%h pc=%0d, want 31c 3", player_cards, player_count);
    end
  endtask

  task automatic test_full();
    do_clear();
    wait_rank(7);
    deal(1'b1, 4'd7,  "full_d0");
    deal(1'b1, 4'd9,  "full_d1");
    deal(1'b1, 4'd11, "full_d2");
    dif.deal_to  = 1'b1;
    dif.deal_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dif.deal_err !== 1'b1 || dif.deal_ack !== 1'b0 || dealer_cards !== 12'hB97 ||
        dealer_count !== 2'd3 || dif.card_value !== 4'd11 || player_count !== 2'd0) begin
      n_fail++;
      $display("FAIL full_err: err=%b ack=%b d=%h dc=%0d card=%0d pc=%0d, want 1 0 b97 3 11 0",
               dif.deal_err, dif.deal_ack, dealer_cards, dealer_count, dif.card_value, player_count);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (dif.deal_err !== 1'b1 || dealer_cards !== 12'hB97) begin
      n_fail++;
      $display("FAIL full_hold: err=%b d=%h, want 1 b97", dif.deal_err, dealer_cards);
    end
    dif.deal_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dif.deal_err !== 1'b0 || dealer_count !== 2'd3) begin
      n_fail++;
      $display("FAIL full_release: err=%b dc=%0d, want 0 3", dif.deal_err, dealer_count);
    end
  endtask

  task automatic test_handshake();
    do_clear();
    wait_rank(4);
    dif.deal_to  = 1'b0;
    dif.deal_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) dif.deal_to = 1'b1;
      n_checks++;
      if (dif.deal_ack !== 1'b1 || player_count !== 2'd1 || player_cards !== 12'h004 ||
          dealer_count !== 2'd0) begin
        n_fail++;
        $display("FAIL handshake_hold[%0d]: ack=%b pc=%0d p=%h dc=%0d, want 1 1 004 0",
                 i, dif.deal_ack, player_count, player_cards, dealer_count);
      end
    end
    dif.deal_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dif.deal_ack !== 1'b0 || player_count !== 2'd1 || dealer_count !== 2'd0) begin
      n_fail++;
      $display("FAIL handshake_release: ack=%b pc=%0d dc=%0d, want 0 1 0",
               dif.deal_ack, player_count, dealer_count);
    end
  endtask

  task automatic test_clear_held();
    do_clear();
    wait_rank(6);
    dif.deal_to  = 1'b0;
    dif.deal_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dif.deal_ack !== 1'b1 || player_cards !== 12'h006) begin
      n_fail++;
      $display("FAIL clear_predeal: ack=%b p=%h, want 1 006", dif.deal_ack, player_cards);
    end
    dif.clear = 1'b1;
    @(negedge clk);
    dif.clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (player_cards !== 12'h0 || player_count !== 2'd0 || dif.card_value !== 4'd0 ||
          dif.deal_ack !== 1'b0 || dif.deal_err !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_held[%0d]: p=%h pc=%0d card=%0d ack=%b err=%b, want all 0",
                 i, player_cards, player_count, dif.card_value, dif.deal_ack, dif.deal_err);
      end
      @(negedge clk);
    end
    dif.deal_req = 1'b0;
    @(negedge clk);
    wait_rank(9);
    deal(1'b0, 4'd9, "clear_redeal");
    n_checks++;
    if (player_cards !== 12'h009 || player_count !== 2'd1) begin
      n_fail++;
      $display("FAIL clear_redeal_slot: p=%h pc=%0d, want 009 1", player_cards, player_count);
    end
  endtask

  task automatic test_reset_ack();
    do_clear();
    dif.deal_to  = 1'b1;
    dif.deal_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dif.deal_ack !== 1'b1 || dealer_count !== 2'd1) begin
      n_fail++;
      $display("FAIL rstack_pre: ack=%b dc=%0d, want 1 1", dif.deal_ack, dealer_count);
    end
    resetb = 1'b0;
    #1;
    n_checks++;
    if (dif.deal_ack !== 1'b0 || dealer_count !== 2'd0 || dealer_cards !== 12'h0 ||
        dif.card_value !== 4'd0) begin
      n_fail++;
      $display("FAIL rstack_async: ack=%b dc=%0d d=%h card=%0d, want 0 0 000 0",
               dif.deal_ack, dealer_count, dealer_cards, dif.card_value);
    end
    dif.deal_req = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    deal(1'b1, 4'd1, "rstack_redeal");
    n_checks++;
    if (dealer_cards !== 12'h001 || dealer_count !== 2'd1) begin
      n_fail++;
      $display("FAIL rstack_slot: d=%h dc=%0d, want 001 1", dealer_cards, dealer_count);
    end
  endtask

  initial begin
    dif.clear    = 1'b0;
    dif.deal_req = 1'b0;
    dif.deal_to  = 1'b0;
    test_reset();
    test_capture();
    test_wrap();
    test_full();
    test_handshake();
    test_clear_held();
    test_reset_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
